mole_round_ctrl: RTL and testbench
==================================

// Module: mole_round_ctrl
// PURPOSE
//  Round sequencer for whack-a-mole; replaces the free-running count==N load strobe.
//  Loads a PRBS pattern onto the 10 mole LEDs and holds it for a display window.
//  Clears moles as the player hits them, and scores each cleared mole.
//  Shortens the window after each fully-cleared round, and ends the game after ROUNDS rounds.
//  Sits between the PRBS generator and button debouncers on one side, and the LED and score display on the other.
// PARAMETERS
//  TICK_MAX    20_000_000  initial display window, clk cycles (>=2)
//  TICK_MIN     5_000_000  floor for the shrinking window (>=2, <=TICK_MAX)
//  TICK_STEP    1_000_000  window reduction after a fully-cleared round
//  GAP_CYCLES   5_000_000  dark interval between rounds, clk cycles (>=1)
//  ROUNDS       30         rounds per game (1..255)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  start      in   1   one-cycle pulse; begins a game (honoured only in IDLE/DONE)
//  random     in   10  PRBS word, sampled in LOAD
//  hit        in   10  one-cycle debounced button pulses, bit i = mole i
//  moles      out  10  lit moles (LED drive)
//  score      out  8   moles hit this game, saturates at 255
//  wrong      out  8   hits on unlit moles this game, saturates at 255
//  round_num  out  8   rounds completed this game
//  busy       out  1   1 in LOAD/SHOW/GAP
//  game_over  out  1   1 in DONE
// BEHAVIOUR
//  Reset: state=IDLE. moles, score, wrong, round_num, busy and game_over are all 0. period=TICK_MAX.
//  Reset mid-game aborts the game immediately; no partial-round effects survive.
//  IDLE: moles=0. start -> LOAD, with score=wrong=round_num=0 and period=TICK_MAX.
//  LOAD (1 cycle): moles<=random, or 10'b1 if random==0. timer<=period-1. -> SHOW.
//  SHOW, each cycle, with v = hit & moles:
//   - moles <= moles & ~v.
//   - score += popcount(v), saturating at 255.
//   - wrong += (|(hit & ~moles)), at most 1 per cycle, saturating.
//   - Exit when the next-cycle moles==0 (cleared) OR timer==0 (expired). Same-cycle hits still count.
//   - On exit: round_num++. If cleared, period = max(period-TICK_STEP, TICK_MIN). If expired only, period is unchanged.
//   - If both occur in the same cycle, it counts as cleared.
//   - Then moles<=0, timer<=GAP_CYCLES-1, -> GAP.
//  GAP: moles=0; hits are ignored (no wrong count). On timer==0: -> DONE if round_num==ROUNDS, else -> LOAD.
//  DONE: moles=0. score, wrong and round_num are held. start -> LOAD with counters cleared as in IDLE.
//  start is ignored in LOAD/SHOW/GAP.
//  The timer is a down-counter, width $clog2(max(TICK_MAX,GAP_CYCLES)+1). Latency from start to moles valid is 2 clk.
//  All outputs are registered.
// STRUCTURE
//  mole_pkg contents: NUM_MOLES=10; state enum {IDLE,LOAD,SHOW,GAP,DONE}; popcount10 function.
//  Sub-module mole_timer: loadable down-counter. Ports are load, load_val, zero.
//  The FSM, score/wrong/round counters and period register live in this top.
// TESTING (bench params: TICK_MAX=8, TICK_MIN=4, TICK_STEP=2, GAP_CYCLES=2, ROUNDS=3)
//  Reset then idle -> moles=0, score=0, busy=0. start with rst high is ignored.
//  start, random=10'h005, no hits -> moles=005 for 8 cycles, then 0 for 2 cycles.
//   After 3 rounds: game_over=1, round_num=3, score=0, period remains 8.
//  Round 1 random=10'h005: hit=10'h001 then hit=10'h004 -> score=2.
//   Round ends early and the next SHOW lasts 6 cycles. A full clear in the next round gives 4, then it stays at 4.
//  hit=10'h003 on moles=10'h001 in one cycle -> score+1, wrong+1, moles=0, exit to GAP.
//  Expiry and final hit in the same cycle -> hit scored, treated as cleared, period shrinks.
//   random=0 -> moles=10'h001.
//  rst asserted mid-SHOW with score=2 -> next cycle: IDLE, all outputs 0. start mid-GAP -> ignored.

Source files
------------

// File: rtl/mole_pkg.sv
`default_nettype none
//==============================================================================
// Module     : mole_pkg
// Description: Shared types and helpers for the whack-a-mole round sequencer.
//              NUM_MOLES  - number of mole LEDs / buttons
//              state_t    - round sequencer states
//              popcount10 - number of set bits in a mole-wide vector
// Revision   : 1.0 - initial release
//==============================================================================
package mole_pkg;

   localparam int NUM_MOLES = 10;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      SHOW = 3'd2,
      GAP  = 3'd3,
      DONE = 3'd4
   } state_t;

   function automatic logic [3:0] popcount10(input logic [NUM_MOLES-1:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < NUM_MOLES; i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mole_timer.sv
`default_nettype none
//==============================================================================
// Module     : mole_timer
// Description: Loadable down-counter that stops at zero.
//              clk      in  1  system clock
//              rst      in  1  synchronous active-high reset (count -> 0)
//              load     in  1  load load_val this cycle
//              load_val in  W  value to load
//              zero     out 1  count is zero
// Revision   : 1.0 - initial release
//==============================================================================
module mole_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - W'(1);
      end
   end

   assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mole_round_ctrl.sv
`default_nettype none
//==============================================================================
// Module     : mole_round_ctrl
// Description: Whack-a-mole round sequencer. Shows a PRBS pattern on the mole
//              LEDs for a display window, clears and scores hit moles, shrinks
//              the window after fully-cleared rounds, ends after ROUNDS rounds.
//              clk       in  1   system clock
//              rst       in  1   synchronous active-high reset
//              start     in  1   begin a game (honoured in IDLE/DONE only)
//              random    in  10  PRBS word, sampled in LOAD
//              hit       in  10  debounced button pulses
//              moles     out 10  lit moles
//              score     out 8   moles hit this game (saturating)
//              wrong     out 8   cycles with hits on unlit moles (saturating)
//              round_num out 8   rounds completed this game
//              busy      out 1   in LOAD/SHOW/GAP
//              game_over out 1   in DONE
// Revision   : 1.0 - initial release
//==============================================================================
module mole_round_ctrl
   import mole_pkg::*;
#(
   parameter int unsigned TICK_MAX   = 20_000_000,
   parameter int unsigned TICK_MIN   = 5_000_000,
   parameter int unsigned TICK_STEP  = 1_000_000,
   parameter int unsigned GAP_CYCLES = 5_000_000,
   parameter int unsigned ROUNDS     = 30
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [NUM_MOLES-1:0] random,
   input  logic [NUM_MOLES-1:0] hit,
   output logic [NUM_MOLES-1:0] moles,
   output logic [7:0]           score,
   output logic [7:0]           wrong,
   output logic [7:0]           round_num,
   output logic                 busy,
   output logic                 game_over
);

   localparam int unsigned TW =
      $clog2(((TICK_MAX > GAP_CYCLES) ? TICK_MAX : GAP_CYCLES) + 1);
   localparam logic [TW-1:0] C_TICK_MAX = TW'(TICK_MAX);
   localparam logic [TW-1:0] C_TICK_MIN = TW'(TICK_MIN);
   localparam logic [TW-1:0] C_STEP     = TW'(TICK_STEP);
   localparam logic [TW-1:0] C_GAP_LAST = TW'(GAP_CYCLES - 1);
   localparam logic [7:0]    C_ROUNDS   = 8'(ROUNDS);

   state_t                 r_state, w_state_n;
   logic [TW-1:0]          r_period, w_period_n;
   logic [NUM_MOLES-1:0]   w_moles_n, w_hit_v, w_left;
   logic [7:0]             w_score_n, w_wrong_n, w_round_n;
   logic [8:0]             w_score_sum;
   logic                   w_tmr_load, w_tmr_zero;
   logic [TW-1:0]          w_tmr_val;

   mole_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (w_tmr_load),
      .load_val (w_tmr_val),
      .zero     (w_tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_period  <= C_TICK_MAX;
         moles     <= '0;
         score     <= '0;
         wrong     <= '0;
         round_num <= '0;
         busy      <= 1'b0;
         game_over <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_period  <= w_period_n;
         moles     <= w_moles_n;
         score     <= w_score_n;
         wrong     <= w_wrong_n;
         round_num <= w_round_n;
         // Status flags follow the next state so they line up with it.
         busy      <= (w_state_n == LOAD) || (w_state_n == SHOW) || (w_state_n == GAP);
         game_over <= (w_state_n == DONE);
      end
   end

   always_comb begin
      w_state_n   = r_state;
      w_period_n  = r_period;
      w_moles_n   = moles;
      w_score_n   = score;
      w_wrong_n   = wrong;
      w_round_n   = round_num;
      w_tmr_load  = 1'b0;
      w_tmr_val   = '0;
      w_hit_v     = hit & moles;
      w_left      = moles & ~w_hit_v;
      w_score_sum = {1'b0, score} + 9'(popcount10(w_hit_v));

      case (r_state)
         IDLE, DONE: begin
            w_moles_n = '0;
            if (start) begin
               w_state_n  = LOAD;
               w_score_n  = '0;
               w_wrong_n  = '0;
               w_round_n  = '0;
               w_period_n = C_TICK_MAX;
            end
         end
         LOAD: begin
            // An all-zero PRBS word would make an unwinnable round; light mole 0.
            w_moles_n  = (random == '0) ? NUM_MOLES'(1) : random;
            w_tmr_load = 1'b1;
            w_tmr_val  = r_period - TW'(1);
            w_state_n  = SHOW;
         end
         SHOW: begin
            w_moles_n = w_left;
            w_score_n = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
            if (((hit & ~moles) != '0) && (wrong != 8'hFF)) begin
               w_wrong_n = wrong + 8'd1;
            end
            // Clearing wins over expiry when both land in the same cycle.
            if ((w_left == '0) || w_tmr_zero) begin
               w_round_n = round_num + 8'd1;
               if (w_left == '0) begin
                  if (32'(r_period) >= TICK_MIN + TICK_STEP) begin
                     w_period_n = r_period - C_STEP;
                  end else begin
                     w_period_n = C_TICK_MIN;
                  end
               end
               w_moles_n  = '0;
               w_tmr_load = 1'b1;
               w_tmr_val  = C_GAP_LAST;
               w_state_n  = GAP;
            end
         end
         GAP: begin
            w_moles_n = '0;
            if (w_tmr_zero) begin
               w_state_n = (round_num == C_ROUNDS) ? DONE : LOAD;
            end
         end
         default: begin
            w_state_n = IDLE;
            w_moles_n = '0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mole_round_ctrl.sv
`default_nettype none
//==============================================================================
// Module     : tb_mole_round_ctrl
// Description: Self-checking bench for mole_round_ctrl. A round-level model
//              tracks lit moles, score, wrong count, rounds and window length.
// Revision   : 1.0 - initial release
//==============================================================================
module tb_mole_round_ctrl;

   localparam int TMAX  = 8;
   localparam int TMIN  = 4;
   localparam int TSTEP = 2;
   localparam int GAPC  = 2;
   localparam int NR    = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [9:0] random;
   logic [9:0] hit;
   logic [9:0] moles;
   logic [7:0] score, wrong, round_num;
   logic       busy, game_over;

   always #5 clk = ~clk;

   mole_round_ctrl #(
      .TICK_MAX   (TMAX),
      .TICK_MIN   (TMIN),
      .TICK_STEP  (TSTEP),
      .GAP_CYCLES (GAPC),
      .ROUNDS     (NR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .random    (random),
      .hit       (hit),
      .moles     (moles),
      .score     (score),
      .wrong     (wrong),
      .round_num (round_num),
      .busy      (busy),
      .game_over (game_over)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Game-level expectations
   int e_score, e_wrong, e_round, e_period;

   // Per-cycle hit plan for directed rounds
   logic [9:0] plan [0:15];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_plan();
      for (int i = 0; i < 16; i++) plan[i] = '0;
   endtask

   task automatic start_game();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL start_precond: busy=%b required 0", busy);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      e_score = 0; e_wrong = 0; e_round = 0; e_period = TMAX;
      n_checks++;
      if (busy !== 1'b1 || game_over !== 1'b0 || score !== 8'd0 ||
          wrong !== 8'd0 || round_num !== 8'd0 || moles !== 10'd0) begin
         n_fail++;
         $display("FAIL start_clear: busy=%b go=%b score=%0d wrong=%0d round=%0d moles=%h required 1 0 0 0 0 000",
                  busy, game_over, score, wrong, round_num, moles);
      end
   endtask

   // Plays one round from the LOAD cycle through the end of its GAP.
   // mode 0: hits from plan[], mode 1: random hits.
   task automatic play_round(input logic [9:0] pat, input int mode, input bit poke_start);
      logic [9:0] m, h, v;
      bit         cleared;
      n_checks++;
      if (busy !== 1'b1 || moles !== 10'd0 || game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL load_entry: busy=%b moles=%h go=%b required 1 000 0", busy, moles, game_over);
      end
      random = pat;
      tick();
      random = 10'($urandom);
      m = (pat == 10'd0) ? 10'h001 : pat;
      cleared = 1'b0;
      for (int j = 0; j < e_period; j++) begin
         n_checks++;
         if (moles !== m) begin
            n_fail++;
            $display("FAIL show_moles: round=%0d cycle=%0d got %h required %h", e_round, j, moles, m);
         end
         if (mode == 0) begin
            h = plan[j];
         end else begin
            h = 10'($urandom & $urandom);
            if ($urandom_range(0, 5) == 0) h = m | 10'($urandom & $urandom);
         end
         hit = h;
         v = h & m;
         e_score = e_score + $countones(v);
         if (e_score > 255) e_score = 255;
         if (((h & ~m) != 10'd0) && e_wrong < 255) e_wrong++;
         m = m & ~v;
         tick();
         hit = '0;
         if (m == 10'd0) begin
            cleared = 1'b1;
            break;
         end
      end
      e_round++;
      if (cleared) e_period = (e_period - TSTEP < TMIN) ? TMIN : e_period - TSTEP;
      n_checks++;
      if (moles !== 10'd0 || busy !== 1'b1 || round_num !== 8'(e_round) ||
          score !== 8'(e_score) || wrong !== 8'(e_wrong)) begin
         n_fail++;
         $display("FAIL round_end: moles=%h busy=%b round=%0d score=%0d wrong=%0d required 000 1 %0d %0d %0d",
                  moles, busy, round_num, score, wrong, e_round, e_score, e_wrong);
      end
      for (int g = 0; g < GAPC; g++) begin
         hit   = 10'($urandom);
         start = poke_start && (g == 0);
         n_checks++;
         if (moles !== 10'd0 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_dark: moles=%h go=%b required 000 0", moles, game_over);
         end
         tick();
         start = 1'b0;
         hit   = '0;
      end
      n_checks++;
      if (score !== 8'(e_score) || wrong !== 8'(e_wrong) ||
          game_over !== (e_round == NR) || busy !== (e_round != NR)) begin
         n_fail++;
         $display("FAIL after_gap: score=%0d wrong=%0d go=%b busy=%b required %0d %0d %b %b",
                  score, wrong, game_over, busy, e_score, e_wrong, e_round == NR, e_round != NR);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; random = 10'h155; hit = 10'h3FF;
      tick(); tick(); tick();
      n_checks++;
      if (busy !== 1'b0 || moles !== 10'd0 || score !== 8'd0 || game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_start_ignored: busy=%b moles=%h score=%0d go=%b required 0 000 0 0",
                  busy, moles, score, game_over);
      end
      start = 1'b0; hit = '0;
      rst = 1'b0;
      tick(); tick();
      n_checks++;
      if (busy !== 1'b0 || moles !== 10'd0 || score !== 8'd0 || wrong !== 8'd0 ||
          round_num !== 8'd0 || game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b moles=%h score=%0d wrong=%0d round=%0d go=%b required all 0",
                  busy, moles, score, wrong, round_num, game_over);
      end
   endtask

   task automatic test_no_hits();
      clear_plan();
      start_game();
      for (int r = 0; r < NR; r++) play_round(10'h005, 0, r == 0);
      tick(); tick(); tick();
      n_checks++;
      if (game_over !== 1'b1 || round_num !== 8'd3 || score !== 8'd0 || moles !== 10'd0) begin
         n_fail++;
         $display("FAIL done_hold: go=%b round=%0d score=%0d moles=%h required 1 3 0 000",
                  game_over, round_num, score, moles);
      end
   endtask

   task automatic test_shrink();
      start_game();
      clear_plan(); plan[0] = 10'h001; plan[1] = 10'h004;
      play_round(10'h005, 0, 1'b0);
      clear_plan(); plan[0] = 10'h3F0;
      play_round(10'h3F0, 0, 1'b0);
      clear_plan();
      play_round(10'h0A0, 0, 1'b0);
   endtask

   task automatic test_edges();
      start_game();
      clear_plan(); plan[0] = 10'h003;
      play_round(10'h001, 0, 1'b0);
      clear_plan(); plan[5] = 10'h001;
      play_round(10'h000, 0, 1'b0);
      clear_plan(); plan[0] = 10'h040; plan[3] = 10'h080;
      play_round(10'h0C0, 0, 1'b0);
   endtask

   task automatic test_reset_mid_show();
      start_game();
      random = 10'h007;
      tick();
      hit = 10'h001; tick();
      hit = 10'h002; tick();
      hit = '0;
      n_checks++;
      if (score !== 8'd2 || moles !== 10'h004) begin
         n_fail++;
         $display("FAIL mid_show: score=%0d moles=%h required 2 004", score, moles);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (moles !== 10'd0 || score !== 8'd0 || wrong !== 8'd0 || round_num !== 8'd0 ||
          busy !== 1'b0 || game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_abort: moles=%h score=%0d wrong=%0d round=%0d busy=%b go=%b required all 0",
                  moles, score, wrong, round_num, busy, game_over);
      end
      // Window must be back at its full length after the abort.
      clear_plan();
      start_game();
      play_round(10'h210, 0, 1'b0);
      tick();
      rst = 1'b1; tick(); rst = 1'b0;
   endtask

   task automatic test_random_games();
      logic [9:0] pat;
      for (int gm = 0; gm < 5; gm++) begin
         start_game();
         for (int r = 0; r < NR; r++) begin
            pat = ($urandom_range(0, 6) == 0) ? 10'd0 : 10'($urandom);
            play_round(pat, 1, $urandom_range(0, 1) == 1);
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; random = '0; hit = '0;
      test_reset();
      test_no_hits();
      test_shrink();
      test_edges();
      test_reset_mid_show();
      test_random_games();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
